// File: rtl/lemming_pkg.sv
// ============================================================================
// Module  : lemming_pkg
// Brief   : Shared state encoding and direction helpers for the lemming walker.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lemming_pkg;

  typedef enum logic [2:0] {
    WALK_L = 3'd0,
    WALK_R = 3'd1,
    FALL_L = 3'd2,
    FALL_R = 3'd3,
    DIG_L  = 3'd4,
    DIG_R  = 3'd5,
    SPLAT  = 3'd6
  } state_t;

  // Direction lives in bit 0 for every directional state (1 = right).
  function automatic logic dir_of(input state_t s);
    return s[0];
  endfunction

  function automatic state_t walk_of(input logic right);
    return right ? WALK_R : WALK_L;
  endfunction

  function automatic state_t fall_of(input logic right);
    return right ? FALL_R : FALL_L;
  endfunction

  function automatic state_t dig_of(input logic right);
    return right ? DIG_R : DIG_L;
  endfunction

  function automatic logic is_fall(input state_t s);
    return (s == FALL_L) || (s == FALL_R);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lemming_4_fall_timer.sv
// ============================================================================
// Module  : fall_timer
// Brief   : Saturating count of consecutive falling cycles with limit flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fall_timer #(
  parameter int FALL_LIMIT = 20,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic areset,
  input  logic falling,
  output logic over_limit
);

  localparam logic [CNT_W-1:0] c_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(FALL_LIMIT);

  generate
    if (((1 << CNT_W) - 1) < (FALL_LIMIT + 1)) begin : g_bad_cnt_w
      $error("fall_timer: CNT_W too narrow for FALL_LIMIT");
    end
  endgenerate

  logic [CNT_W-1:0] r_count;

  // Count holds N-1 during the Nth falling cycle, so the landing edge of the
  // (FALL_LIMIT+1)th cycle is the first one that sees the flag.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_count <= '0;
    end else if (!falling) begin
      r_count <= '0;
    end else if (r_count != c_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign over_limit = (r_count >= c_limit);

endmodule

`default_nettype wire

// File: rtl/lemming_4.sv
// ============================================================================
// Module  : lemming_4
// Brief   : Moore FSM for one lemming: walk, bump, fall, dig and splat.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lemming_4
  import lemming_pkg::*;
#(
  parameter int FALL_LIMIT = 20,
  parameter int CNT_W      = 5
) (
  input  logic clk,
  input  logic areset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic dead
);

  state_t r_state;
  state_t w_next;
  logic   w_over_limit;
  logic   w_stay_falling;
  logic   r_walk_left;
  logic   r_walk_right;
  logic   r_aaah;
  logic   r_digging;
  logic   r_dead;

  always_comb begin
    w_next = r_state;
    case (r_state)
      WALK_L, WALK_R: begin
        if (!ground) begin
          w_next = fall_of(dir_of(r_state));
        end else if (dig) begin
          w_next = dig_of(dir_of(r_state));
        end else if (r_state == WALK_L && bump_left) begin
          w_next = WALK_R;
        end else if (r_state == WALK_R && bump_right) begin
          w_next = WALK_L;
        end
      end
      FALL_L, FALL_R: begin
        if (ground) begin
          w_next = w_over_limit ? SPLAT : walk_of(dir_of(r_state));
        end
      end
      DIG_L, DIG_R: begin
        if (!ground) begin
          w_next = fall_of(dir_of(r_state));
        end
      end
      SPLAT:   w_next = SPLAT;
      default: w_next = WALK_L;
    endcase
  end

  assign w_stay_falling = is_fall(r_state) && is_fall(w_next);

  fall_timer #(
    .FALL_LIMIT (FALL_LIMIT),
    .CNT_W      (CNT_W)
  ) u_fall_timer (
    .clk        (clk),
    .areset     (areset),
    .falling    (w_stay_falling),
    .over_limit (w_over_limit)
  );

  // Outputs are registered alongside the state so they stay one-hot and free
  // of any input-to-output path.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state      <= WALK_L;
      r_walk_left  <= 1'b1;
      r_walk_right <= 1'b0;
      r_aaah       <= 1'b0;
      r_digging    <= 1'b0;
      r_dead       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_walk_left  <= (w_next == WALK_L);
      r_walk_right <= (w_next == WALK_R);
      r_aaah       <= is_fall(w_next);
      r_digging    <= (w_next == DIG_L) || (w_next == DIG_R);
      r_dead       <= (w_next == SPLAT);
    end
  end

  assign walk_left  = r_walk_left;
  assign walk_right = r_walk_right;
  assign aaah       = r_aaah;
  assign digging    = r_digging;
  assign dead       = r_dead;

endmodule

`default_nettype wire

// File: tb/tb_lemming_4.sv
// ============================================================================
// Module  : tb_lemming_4
// Brief   : Directed scoreboard bench for lemming_4 against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lemming_4;

  localparam int LIMIT = 20;

  logic clk = 1'b0;
  logic areset;
  logic bump_left;
  logic bump_right;
  logic ground;
  logic dig;
  logic walk_left;
  logic walk_right;
  logic aaah;
  logic digging;
  logic dead;

  always #5 clk = ~clk;

  lemming_4 #(
    .FALL_LIMIT (LIMIT),
    .CNT_W      (5)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .bump_left  (bump_left),
    .bump_right (bump_right),
    .ground     (ground),
    .dig        (dig),
    .walk_left  (walk_left),
    .walk_right (walk_right),
    .aaah       (aaah),
    .digging    (digging),
    .dead       (dead)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [4:0] exp_q[$];

  // Model: mode 0 walk, 1 fall, 2 dig, 3 dead; m_n = cycles spent falling.
  int   m_mode;
  logic m_dir;
  int   m_n;

  localparam logic [4:0] c_out_wl = 5'b10000;

  function automatic logic [4:0] model_out(input int mode, input logic dir);
    case (mode)
      0:       return dir ? 5'b01000 : 5'b10000;
      1:       return 5'b00100;
      2:       return 5'b00010;
      default: return 5'b00001;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_dir  = 1'b0;
    m_n    = 0;
  endtask

  task automatic model_step(input logic bl, input logic br, input logic g, input logic d);
    case (m_mode)
      0: begin
        if (!g) begin
          m_mode = 1;
          m_n    = 1;
        end else if (d) begin
          m_mode = 2;
        end else if (!m_dir && bl) begin
          m_dir = 1'b1;
        end else if (m_dir && br) begin
          m_dir = 1'b0;
        end
      end
      1: begin
        if (g) m_mode = (m_n > LIMIT) ? 3 : 0;
        else   m_n    = m_n + 1;
      end
      2: begin
        if (!g) begin
          m_mode = 1;
          m_n    = 1;
        end
      end
      default: m_mode = 3;
    endcase
  endtask

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {walk_left, walk_right, aaah, digging, dead};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic bl, input logic br,
                      input logic g, input logic d);
    @(negedge clk);
    bump_left  = bl;
    bump_right = br;
    ground     = g;
    dig        = d;
    model_step(bl, br, g, d);
    exp_q.push_back(model_out(m_mode, m_dir));
    @(posedge clk);
    #1;
    check(tag, exp_q.pop_front());
  endtask

  // Reset pulse fully between edges; output must change before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 areset = 1'b1;
    #1 check(tag, c_out_wl);
    areset = 1'b0;
    model_reset();
  endtask

  task automatic fall_then_land(input string tag, input int n);
    for (int i = 0; i < n; i++) step({tag, "_fall"}, 1'b0, 1'b0, 1'b0, 1'b0);
    step({tag, "_land"}, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    areset     = 1'b1;
    bump_left  = 1'b0;
    bump_right = 1'b0;
    ground     = 1'b1;
    dig        = 1'b0;
    model_reset();
    #1 check("reset_initial", c_out_wl);
    repeat (2) begin
      @(posedge clk);
      #1 check("reset_hold", c_out_wl);
    end
    @(negedge clk);
    areset = 1'b0;

    step("walk_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    step("bump_left", 1'b1, 1'b0, 1'b1, 1'b0);
    step("walk_right_hold", 1'b0, 1'b0, 1'b1, 1'b0);
    step("both_bumps_a", 1'b1, 1'b1, 1'b1, 1'b0);
    step("both_bumps_b", 1'b1, 1'b1, 1'b1, 1'b0);

    // Short fall from WALK_R with a bump mid-fall.
    for (int i = 0; i < 5; i++) step("short_fall", 1'b0, (i == 2), 1'b0, 1'b0);
    step("short_land", 1'b0, 1'b0, 1'b1, 1'b0);

    fall_then_land("limit_20", LIMIT);

    // Landing edge with a bump: bump ignored.
    step("pre_bump_land", 1'b0, 1'b0, 1'b0, 1'b0);
    step("bump_on_land", 1'b0, 1'b1, 1'b1, 1'b0);
    step("bump_after_land", 1'b0, 1'b1, 1'b1, 1'b0);

    // Dig from WALK_L.
    step("dig_start", 1'b0, 1'b0, 1'b1, 1'b1);
    step("dig_bumps", 1'b1, 1'b1, 1'b1, 1'b0);
    step("dig_again", 1'b0, 1'b0, 1'b1, 1'b1);
    fall_then_land("dig_fall", 3);

    step("priority", 1'b1, 1'b0, 1'b0, 1'b1);
    step("priority_land", 1'b0, 1'b0, 1'b1, 1'b0);
    step("dig_with_bump", 1'b1, 1'b0, 1'b1, 1'b1);
    step("dig_fall_out", 1'b0, 1'b0, 1'b0, 1'b0);
    step("dig_fall_land", 1'b0, 1'b0, 1'b1, 1'b0);

    fall_then_land("limit_21", LIMIT + 1);
    for (int i = 0; i < 10; i++)
      step("dead_hold", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    async_reset("reset_in_splat");
    step("after_splat_reset", 1'b0, 1'b0, 1'b1, 1'b0);

    fall_then_land("saturate_40", 40);
    async_reset("reset_after_sat");

    // Fall right, reset at cycle 15, then a full-limit fall must survive.
    step("to_right", 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step("fall_r_15", 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset("reset_mid_fall");
    step("post_reset_walk", 1'b0, 1'b0, 1'b1, 1'b0);
    fall_then_land("refall_20", LIMIT);
    fall_then_land("refall_short", 2);
    fall_then_land("refall_20b", LIMIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
